spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter CPOL, default 0: SCK idle level; 0 samples MOSI on rising SCK, 1 samples on falling SCK.
REQ-002 Parameter STATUS, default 8'hA5: byte shifted out on MISO during the command byte.
REQ-003 CLK  input  1  system clock; all state on rising CLK.
REQ-004 nRESET  input  1  asynchronous active-low reset.
REQ-005 SCK  input  1  SPI clock from the Gigatron extension master; asynchronous to CLK.
REQ-006 MOSI  input  1  SPI data in, MSB first.
REQ-007 nSS  input  1  active-low select; asynchronous to CLK.
REQ-008 MISO  output  1  SPI data out, MSB first.
REQ-009 MISO_OE  output  1  high while selected; the pad tristates MISO when low.
REQ-010 REGS  output  64  register file, reg[i] on bits 8i+7:8i.
REQ-011 HWE  input  1  host write strobe, one CLK.
REQ-012 HADDR  input  3  host write address.
REQ-013 HDATA  input  8  host write data.
REQ-014 WSTB  output  1  one-CLK pulse when an SPI write commits a register.
REQ-015 WADDR  output  3  address of the SPI write committed with WSTB.

Function
REQ-016 The block SHALL pass SCK, MOSI and nSS through 2-flop synchronizers and act only on the synchronized values.
REQ-017 Edge detection SHALL compare the synchronized value with a third delayed copy of it; the block SHALL require CLK >= 4x SCK.
REQ-018 The sample edge SHALL be rising SCK when CPOL=0 and falling SCK when CPOL=1; the shift edge SHALL be the other edge.
REQ-019 The state machine SHALL have the states IDLE, CMD and DATA.
REQ-020 In IDLE, a synchronized nSS fall SHALL enter CMD, clear the 3-bit bit counter, load STATUS into the tx shifter, and set MISO_OE=1.
REQ-021 On each sample edge the block SHALL shift MOSI into the rx shifter LSB and increment the bit counter mod 8.
REQ-022 The 8th sample edge in CMD SHALL latch RW=rx[7] (1 = write) and ADDR=rx[2:0], and SHALL enter DATA; rx[6:3] are ignored.
REQ-023 On a shift edge the tx shifter SHALL shift left by one, except on the first shift edge after a completed byte.
REQ-024 On that first shift edge after a completed byte, the tx shifter SHALL load reg[ADDR] if RW=0, or 8'h00 if RW=1.
REQ-025 MISO SHALL always equal tx[7].
REQ-026 The 8th sample edge in DATA with RW=1 SHALL write rx to reg[ADDR] and pulse WSTB with WADDR=ADDR in the same CLK.
REQ-027 Each completed byte in DATA SHALL then increment ADDR mod 8 (7 wraps to 0).
REQ-028 A synchronized nSS rise in any state SHALL return to IDLE, discard any partial byte without writing, and set MISO_OE=0.
REQ-029 Sample and shift edges SHALL be ignored in IDLE.
REQ-030 HWE=1 SHALL write HDATA to reg[HADDR] in that CLK.
REQ-031 If HWE and an SPI commit hit the same address in the same CLK, the SPI data SHALL win; if the addresses differ, both writes SHALL occur.
REQ-032 A read byte SHALL reflect reg[ADDR] as of its load edge; later writes SHALL not alter a byte already in the shifter.
REQ-033 REGS SHALL be registered directly from the register file with no extra latency.

Reset
REQ-034 nRESET low SHALL immediately force: state IDLE, all registers 0, rx, tx and bit counter 0, ADDR 0, RW 0, MISO 0, MISO_OE 0, WSTB 0, WADDR 0, synchronizers to idle (SCK=CPOL, nSS=1).
REQ-035 Reset asserted mid-transfer SHALL abort the transfer; the first nSS fall after release SHALL start a fresh CMD.

Verification
REQ-036 Write burst, CPOL=0: nSS low, bytes 8'h86, 8'h11, 8'h22, 8'h33, nSS high -> reg6=11, reg7=22, reg0=33; WSTB fires three times with WADDR 6, 7, 0.
REQ-037 Read: host writes reg2=8'hC3; SPI sends 8'h02, 8'h00, 8'h00 -> MISO bytes A5, C3, reg3 value; MISO_OE=1 only while nSS is low.
REQ-038 Abort: nSS rises after 5 bits of the data byte of write 8'h81, 8'hFF -> reg1 unchanged, no WSTB; next transaction decodes correctly.
REQ-039 Collision: HWE to addr 4 with HDATA=8'h55 in the same CLK as an SPI commit of 8'hAA to addr 4 -> reg4=8'hAA.
REQ-040 CPOL=1 instance repeats REQ-036 with inverted SCK -> identical register results.
REQ-041 Async reset pulsed mid-byte -> all outputs 0 within the reset; next write 8'h80, 8'h7E sets reg0=8'h7E.

Source files
------------

// File: rtl/spi_target.sv
// SPI target with an 8-entry register file: command byte selects read/write and address,
// following data bytes stream to or from consecutive registers. Host port writes in parallel.
module spi_target #(
    parameter bit         CPOL   = 1'b0,
    parameter logic [7:0] STATUS = 8'hA5
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        SCK,
    input  logic        MOSI,
    input  logic        nSS,
    output logic        MISO,
    output logic        MISO_OE,
    output logic [63:0] REGS,
    input  logic        HWE,
    input  logic [2:0]  HADDR,
    input  logic [7:0]  HDATA,
    output logic        WSTB,
    output logic [2:0]  WADDR
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [2:0] sck_q;
    logic [2:0] nss_q;
    logic [1:0] mosi_q;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [2:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       load_q, load_d;
    logic       wstb_q;
    logic [2:0] waddr_q;
    logic [7:0] regs_q [8];

    logic       sck_rise, sck_fall, sample_edge, shift_edge;
    logic       nss_fall, nss_rise;
    logic       commit;
    logic [7:0] rx_next;

    // Bit 1 is the synchronized value, bit 2 its delayed copy for edge detection.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sck_q  <= {3{CPOL}};
            nss_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], SCK};
            nss_q  <= {nss_q[1:0], nSS};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign sck_rise    = sck_q[1] & ~sck_q[2];
    assign sck_fall    = ~sck_q[1] & sck_q[2];
    assign sample_edge = CPOL ? sck_fall : sck_rise;
    assign shift_edge  = CPOL ? sck_rise : sck_fall;
    assign nss_fall    = ~nss_q[1] & nss_q[2];
    assign nss_rise    = nss_q[1] & ~nss_q[2];
    assign rx_next     = {rx_q[6:0], mosi_q[1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        load_d  = load_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    state_d = CMD;
                    cnt_d   = 3'd0;
                    rx_d    = 8'h00;
                    tx_d    = STATUS;
                    oe_d    = 1'b1;
                    load_d  = 1'b0;
                end
            end
            CMD, DATA: begin
                if (nss_rise) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    rx_d    = 8'h00;
                    oe_d    = 1'b0;
                    load_d  = 1'b0;
                end else if (sample_edge) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        load_d = 1'b1;
                        if (state_q == CMD) begin
                            rw_d    = rx_next[7];
                            addr_d  = rx_next[2:0];
                            state_d = DATA;
                        end else begin
                            commit = rw_q;
                            addr_d = addr_q + 3'd1;
                        end
                    end
                end else if (shift_edge) begin
                    // The first shift after a full byte fetches the next outgoing byte.
                    if (load_q) begin
                        tx_d   = rw_q ? 8'h00 : regs_q[addr_q];
                        load_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rx_q    <= 8'h00;
            tx_q    <= 8'h00;
            addr_q  <= 3'd0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            load_q  <= load_d;
        end
    end

    // SPI commit is applied after the host write so it wins on an address clash.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
            wstb_q  <= 1'b0;
            waddr_q <= 3'd0;
        end else begin
            if (HWE) regs_q[HADDR] <= HDATA;
            if (commit) begin
                regs_q[addr_q] <= rx_next;
                waddr_q        <= addr_q;
            end
            wstb_q <= commit;
        end
    end

    always_comb begin
        REGS = '0;
        for (int i = 0; i < 8; i++) REGS[8*i +: 8] = regs_q[i];
    end

    assign MISO    = tx_q[7];
    assign MISO_OE = oe_q;
    assign WSTB    = wstb_q;
    assign WADDR   = waddr_q;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a CPOL=0 and a CPOL=1 instance run the same SPI traffic
// (inverted SCK), checked against a byte-level model of the register file.
`timescale 1ns/1ps
module tb_spi_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck0 = 1'b0;
    logic        sck1;
    logic        mosi = 1'b0;
    logic        nss = 1'b1;
    logic        hwe = 1'b0;
    logic [2:0]  haddr = 3'd0;
    logic [7:0]  hdata = 8'h00;

    logic        miso0, miso1, oe0, oe1, wstb0, wstb1;
    logic [63:0] regs0, regs1;
    logic [2:0]  waddr0, waddr1;

    int total = 0;
    int bad = 0;

    logic [7:0]  mregs [8];
    logic [7:0]  exp_miso [$];
    logic [10:0] exp_w0 [$];
    logic [10:0] exp_w1 [$];

    assign sck1 = ~sck0;
    always #5 clk = ~clk;

    spi_target #(.CPOL(1'b0), .STATUS(8'hA5)) u_dut0 (
        .CLK(clk), .nRESET(rst_n), .SCK(sck0), .MOSI(mosi), .nSS(nss),
        .MISO(miso0), .MISO_OE(oe0), .REGS(regs0),
        .HWE(hwe), .HADDR(haddr), .HDATA(hdata), .WSTB(wstb0), .WADDR(waddr0));

    spi_target #(.CPOL(1'b1), .STATUS(8'hA5)) u_dut1 (
        .CLK(clk), .nRESET(rst_n), .SCK(sck1), .MOSI(mosi), .nSS(nss),
        .MISO(miso1), .MISO_OE(oe1), .REGS(regs1),
        .HWE(hwe), .HADDR(haddr), .HDATA(hdata), .WSTB(wstb1), .WADDR(waddr1));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model_regs();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mregs[i];
        return r;
    endfunction

    task automatic cmp_regs(input string nm);
        check({nm, "_regs0"}, regs0, model_regs());
        check({nm, "_regs1"}, regs1, model_regs());
    endtask

    // MISO monitor: master-side view, sampling on the CPOL=0 rising edge.
    int         mcnt = 0;
    logic [7:0] acc0 = 8'h00;
    logic [7:0] acc1 = 8'h00;
    always @(posedge sck0 or posedge nss) begin
        if (nss) begin
            mcnt = 0;
        end else begin
            check("miso_oe_selected", {oe0, oe1}, 2'b11);
            acc0 = {acc0[6:0], miso0};
            acc1 = {acc1[6:0], miso1};
            mcnt++;
            if (mcnt == 8) begin
                mcnt = 0;
                if (exp_miso.size() == 0) begin
                    check("miso_unexpected_byte", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_miso.pop_front();
                    check("miso_byte0", acc0, e);
                    check("miso_byte1", acc1, e);
                end
            end
        end
    end

    // Write-commit monitors.
    always @(negedge clk) begin
        if (rst_n && wstb0) begin
            if (exp_w0.size() == 0) check("wstb0_unexpected", 1, 0);
            else begin
                logic [10:0] e;
                e = exp_w0.pop_front();
                check("waddr0", waddr0, e[10:8]);
                check("wdata0", regs0[{e[10:8], 3'b000} +: 8], e[7:0]);
            end
        end
        if (rst_n && wstb1) begin
            if (exp_w1.size() == 0) check("wstb1_unexpected", 1, 0);
            else begin
                logic [10:0] e;
                e = exp_w1.pop_front();
                check("waddr1", waddr1, e[10:8]);
                check("wdata1", regs1[{e[10:8], 3'b000} +: 8], e[7:0]);
            end
        end
    end

    task automatic spi_bit(input logic bv, input bit hw);
        mosi = bv;
        repeat (6) @(negedge clk);
        sck0 = 1'b1;
        if (hw) begin
            // Host strobe lands on the CLK edge where the synchronized sample edge commits.
            repeat (2) @(negedge clk);
            hwe = 1'b1;
            @(negedge clk);
            hwe = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        sck0 = 1'b0;
    endtask

    task automatic hwrite(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        haddr = a;
        hdata = d;
        hwe   = 1'b1;
        @(negedge clk);
        hwe = 1'b0;
        mregs[a] = d;
    endtask

    // nb bytes (command first); the final byte sends only lastbits bits; coll = byte index
    // whose last bit is accompanied by a host write using the current haddr/hdata.
    task automatic xfer(input logic [7:0] b0, b1, b2, b3, b4,
                        input int nb, input int lastbits, input int coll);
        logic [7:0] d [5];
        logic       rw;
        logic [2:0] a;
        int         nbits;
        d = '{b0, b1, b2, b3, b4};
        rw = d[0][7];
        a  = d[0][2:0];
        @(negedge clk);
        nss = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            nbits = (k == nb - 1) ? lastbits : 8;
            if (nbits == 8) begin
                if (k == 0) exp_miso.push_back(8'hA5);
                else begin
                    exp_miso.push_back(rw ? 8'h00 : mregs[a]);
                    if (rw) begin
                        mregs[a] = d[k];
                        exp_w0.push_back({a, d[k]});
                        exp_w1.push_back({a, d[k]});
                    end
                    a = a + 3'd1;
                end
            end
            for (int i = 0; i < nbits; i++) spi_bit(d[k][7-i], (k == coll) && (i == 7));
        end
        repeat (6) @(negedge clk);
        nss = 1'b1;
        repeat (6) @(negedge clk);
        check("miso_oe_deselected", {oe0, oe1}, 2'b00);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_regs0"}, regs0, 64'h0);
        check({nm, "_regs1"}, regs1, 64'h0);
        check({nm, "_miso"}, {miso0, miso1}, 2'b00);
        check({nm, "_oe"}, {oe0, oe1}, 2'b00);
        check({nm, "_wstb"}, {wstb0, wstb1}, 2'b00);
        check({nm, "_waddr"}, {waddr0, waddr1}, 6'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write burst wrapping 7 -> 0.
        xfer(8'h86, 8'h11, 8'h22, 8'h33, 8'h00, 4, 8, -1);
        cmp_regs("burst");
        check("burst_reg6", regs0[55:48], 8'h11);
        check("burst_reg0", regs1[7:0], 8'h33);

        // Read back a host-written register.
        hwrite(3'd3, 8'h5C);
        hwrite(3'd2, 8'hC3);
        xfer(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8, -1);
        cmp_regs("read");

        // Abort after 5 data bits, then a clean transaction.
        xfer(8'h81, 8'hFF, 8'h00, 8'h00, 8'h00, 2, 5, -1);
        cmp_regs("abort");
        check("abort_reg1", regs0[15:8], 8'h00);
        xfer(8'h81, 8'h5A, 8'h00, 8'h00, 8'h00, 2, 8, -1);
        cmp_regs("after_abort");

        // Host and SPI write the same register in the same CLK.
        haddr = 3'd4;
        hdata = 8'h55;
        xfer(8'h84, 8'hAA, 8'h00, 8'h00, 8'h00, 2, 8, 1);
        cmp_regs("collision");
        check("collision_reg4", regs0[39:32], 8'hAA);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            logic [7:0] c;
            if ($urandom_range(0, 2) == 0)
                hwrite(3'($urandom_range(0, 7)), 8'($urandom));
            c = {1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom_range(0, 7))};
            xfer(c, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(2, 5), 8, -1);
        end
        cmp_regs("random");

        // Asynchronous reset in the middle of a command byte.
        @(negedge clk);
        nss = 1'b0;
        repeat (6) @(negedge clk);
        spi_bit(1'b1, 1'b0);
        spi_bit(1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        nss = 1'b1;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        xfer(8'h80, 8'h7E, 8'h00, 8'h00, 8'h00, 2, 8, -1);
        cmp_regs("post_reset");
        check("post_reset_reg0", regs1[7:0], 8'h7E);

        repeat (10) @(negedge clk);
        check("miso_queue_left", exp_miso.size(), 0);
        check("w0_queue_left", exp_w0.size(), 0);
        check("w1_queue_left", exp_w1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
